// File: rtl/ether_rx_if.sv
// RMII receive-side bundle: PHY dibit/carrier inputs and the filtered payload stream.
interface ether_rx_if;
  logic [1:0] rxd;
  logic       crsdv;
  logic       axiov;
  logic [1:0] axiod;

  modport master (
    output rxd,
    output crsdv,
    input  axiov,
    input  axiod
  );

  modport slave (
    input  rxd,
    input  crsdv,
    output axiov,
    output axiod
  );
endinterface

// File: rtl/ether_rx.sv
// RMII receive front-end: checks the 31x01 + 11 lead-in of each frame and
// forwards only the dibits after the SFD; malformed frames are dropped whole.
module ether_rx (
  input  logic        clk,
  input  logic        rst,
  ether_rx_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    BAD
  } state_t;

  state_t     state;
  logic [4:0] cnt;

  // Frame tracker: counts 01 dibits of the lead-in, saturating at 31, and any loss of carrier returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else if (!bus.crsdv) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          case (bus.rxd)
            2'b00: begin
              state <= IDLE;
              cnt   <= 5'd0;
            end
            2'b01: begin
              state <= PREAMBLE;
              cnt   <= 5'd1;
            end
            default: state <= BAD;
          endcase
        end
        PREAMBLE: begin
          case (bus.rxd)
            2'b01: begin
              if (cnt != 5'd31) cnt <= cnt + 5'd1;
            end
            2'b11: begin
              if (cnt == 5'd31) state <= DATA;
              else              state <= BAD;
            end
            default: state <= BAD;
          endcase
        end
        DATA:    state <= DATA;
        BAD:     state <= BAD;
        default: state <= BAD;
      endcase
    end
  end

  // Payload is passed straight through while in DATA so the first dibit after the SFD has no latency.
  always_comb begin
    bus.axiov = (state == DATA) && bus.crsdv;
    bus.axiod = bus.axiov ? bus.rxd : 2'b00;
  end

endmodule

// File: tb/tb_ether_rx.sv
// Directed bench for ether_rx: good, corrupt and short lead-ins, frame restart and reset mid-payload.
module tb_ether_rx;

  logic clk;
  logic rst;
  int   vec_count;
  int   err_count;

  ether_rx_if bus ();

  ether_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // 50 MHz reference clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Guard against a run that never ends
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    vec_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %b, required %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one dibit on the falling edge and checks the combinational outputs in the same cycle.
  task automatic apply_stimulus(input string tag, input logic cv, input logic [1:0] d,
                                input logic ev, input logic [1:0] ed);
    @(negedge clk);
    bus.crsdv = cv;
    bus.rxd   = d;
    #2;
    check_output({tag, ".axiov"}, {1'b0, bus.axiov}, {1'b0, ev});
    check_output({tag, ".axiod"}, bus.axiod, ed);
  endtask

  task automatic send_ones(input string tag, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(tag, 1'b1, 2'b01, 1'b0, 2'b00);
  endtask

  // Payload alternates 10/01 starting at 10; good frames must show it, dropped ones must not.
  task automatic send_payload(input string tag, input int n, input logic good);
    logic [1:0] d;
    for (int i = 0; i < n; i++) begin
      d = (i % 2 == 0) ? 2'b10 : 2'b01;
      apply_stimulus(tag, 1'b1, d, good, good ? d : 2'b00);
    end
  endtask

  task automatic end_frame(input string tag);
    apply_stimulus(tag, 1'b0, 2'b00, 1'b0, 2'b00);
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;
    rst       = 1'b0;
    bus.crsdv = 1'b0;
    bus.rxd   = 2'b00;

    // Reset state, even with carrier and SFD-like data on the pins
    apply_stimulus("reset_idle", 1'b0, 2'b00, 1'b0, 2'b00);
    apply_stimulus("reset_busy", 1'b1, 2'b11, 1'b0, 2'b00);
    @(negedge clk);
    bus.crsdv = 1'b0;
    rst       = 1'b1;

    // Good frame with one tolerated 00 before the preamble
    apply_stimulus("good_lead00", 1'b1, 2'b00, 1'b0, 2'b00);
    send_ones("good_pre", 31);
    apply_stimulus("good_sfd", 1'b1, 2'b11, 1'b0, 2'b00);
    send_payload("good_pay", 10, 1'b1);
    end_frame("good_end");

    // Payload values of 00 and 11 pass through as well
    send_ones("vals_pre", 31);
    apply_stimulus("vals_sfd", 1'b1, 2'b11, 1'b0, 2'b00);
    apply_stimulus("vals_00", 1'b1, 2'b00, 1'b1, 2'b00);
    apply_stimulus("vals_11", 1'b1, 2'b11, 1'b1, 2'b11);
    apply_stimulus("vals_01", 1'b1, 2'b01, 1'b1, 2'b01);
    end_frame("vals_end");

    // Corrupt preamble: a 00 after 27 ones
    send_ones("cpre_pre", 27);
    apply_stimulus("cpre_00", 1'b1, 2'b00, 1'b0, 2'b00);
    send_ones("cpre_pre2", 2);
    apply_stimulus("cpre_sfd", 1'b1, 2'b11, 1'b0, 2'b00);
    send_payload("cpre_pay", 6, 1'b0);
    end_frame("cpre_end");

    // Corrupt SFD: 10 instead of 11
    send_ones("csfd_pre", 31);
    apply_stimulus("csfd_sfd", 1'b1, 2'b10, 1'b0, 2'b00);
    send_payload("csfd_pay", 6, 1'b0);
    end_frame("csfd_end");

    // Short preamble of 20 ones
    send_ones("short_pre", 20);
    apply_stimulus("short_sfd", 1'b1, 2'b11, 1'b0, 2'b00);
    send_payload("short_pay", 6, 1'b0);
    end_frame("short_end");

    // One short of the required count
    send_ones("p30_pre", 30);
    apply_stimulus("p30_sfd", 1'b1, 2'b11, 1'b0, 2'b00);
    send_payload("p30_pay", 4, 1'b0);
    end_frame("p30_end");

    // Longer preamble: count saturates at 31, frame still accepted
    send_ones("p35_pre", 35);
    apply_stimulus("p35_sfd", 1'b1, 2'b11, 1'b0, 2'b00);
    send_payload("p35_pay", 4, 1'b1);
    end_frame("p35_end");

    // Frame end mid-payload and immediate restart
    send_ones("restart_pre", 31);
    apply_stimulus("restart_sfd", 1'b1, 2'b11, 1'b0, 2'b00);
    send_payload("restart_pay", 4, 1'b1);
    apply_stimulus("restart_drop", 1'b0, 2'b10, 1'b0, 2'b00);
    send_ones("restart_pre2", 31);
    apply_stimulus("restart_sfd2", 1'b1, 2'b11, 1'b0, 2'b00);
    send_payload("restart_pay2", 6, 1'b1);
    end_frame("restart_end");

    // Reset asserted while payload is flowing
    send_ones("rstmid_pre", 31);
    apply_stimulus("rstmid_sfd", 1'b1, 2'b11, 1'b0, 2'b00);
    send_payload("rstmid_pay", 3, 1'b1);
    apply_stimulus("rstmid_live", 1'b1, 2'b10, 1'b1, 2'b10);
    #1;
    rst = 1'b0;
    #1;
    check_output("rstmid_async.axiov", {1'b0, bus.axiov}, 2'b00);
    check_output("rstmid_async.axiod", bus.axiod, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    send_payload("rstmid_rest", 6, 1'b0);
    end_frame("rstmid_end");

    // Recovery after the reset
    send_ones("recover_pre", 31);
    apply_stimulus("recover_sfd", 1'b1, 2'b11, 1'b0, 2'b00);
    send_payload("recover_pay", 4, 1'b1);
    end_frame("recover_end");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
